// File: rtl/reload_sequencer.sv
// Reload sequencer: buffers reload values in a small FIFO and strobes them into a
// loadable counter, priming once, then reloading each time the counter hits TERM.
module reload_sequencer #(
  parameter int unsigned       DATA_W = 4,
  parameter int unsigned       DEPTH  = 4,
  parameter logic [DATA_W-1:0] TERM   = {DATA_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        cnt_in,
  output logic                     load,
  output logic [DATA_W-1:0]        load_val,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic                load_q, load_d;
  logic [DATA_W-1:0]   load_val_q, load_val_d;
  logic                underrun_q, underrun_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic push, pop, not_empty, trigger;

  assign in_ready  = (level_q != LvlW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign not_empty = (level_q != '0);
  // Gating on load_q keeps a strobe in flight from being reissued.
  assign trigger   = (cnt_in == TERM) && !load_q;

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    underrun_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (not_empty) begin
          pop     = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (trigger) begin
          if (not_empty) begin
            pop = 1'b1;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load_d     = pop;
    load_val_d = pop ? mem[rd_ptr_q] : load_val_q;
    level_d    = level_q + LvlW'(push) - LvlW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      load_q     <= 1'b0;
      load_val_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      underrun_q <= underrun_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  assign load     = load_q;
  assign load_val = load_val_q;
  assign level    = level_q;
  assign underrun = underrun_q;

endmodule
